// File: rtl/core_share_arb.sv
// core_share_arb: round-robin time-sharing of one combinational core among NREQ requesters.
// Define CORE_ARB_STATS_EN to build the saturating per-requester grant counters.
module core_share_arb #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IN_W   = 14,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*IN_W-1:0]  req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [OUT_W-1:0]      rsp_data,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [IN_W-1:0]       core_in,
    input  logic [OUT_W-1:0]      core_out,
    output logic                  busy,
    input  logic                  stats_clr,
    output logic [NREQ*CNT_W-1:0] grant_cnt
);

    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   win_idx;
    logic            win_found;
    logic [GW:0]     rr_sum;
    logic [GW-1:0]   rr_idx;
    logic [SW-1:0]   settle_cnt;
    logic [IN_W-1:0] win_data;
    logic            hs_req;

    // Search starts one past the last winner and wraps modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            rr_sum = {1'b0, last_grant} + (GW+1)'(k);
            rr_idx = (rr_sum >= (GW+1)'(NREQ)) ? GW'(rr_sum - (GW+1)'(NREQ)) : rr_sum[GW-1:0];
            if (!win_found && req_valid[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == GW'(i)) win_data = req_data[i*IN_W +: IN_W];
        end
    end

    assign hs_req    = (state == ST_IDLE) && win_found;
    assign req_ready = (hs_req && rst_n) ? (ONE_HOT0 << win_idx) : '0;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= GW'(NREQ - 1);
            settle_cnt <= '0;
            core_in    <= '0;
            rsp_data   <= '0;
            rsp_valid  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hs_req) begin
                        core_in    <= win_data;
                        last_grant <= win_idx;
                        settle_cnt <= SW'(SETTLE - 1);
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end else begin
                        rsp_data  <= core_out;
                        rsp_valid <= ONE_HOT0 << last_grant;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[last_grant]) begin
                        rsp_valid <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CORE_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NREQ];

    // Clear takes priority over a coincident grant; counters saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (stats_clr) begin
                    cnt_q[i] <= '0;
                end else if (req_ready[i] && cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign grant_cnt        = '0;
`endif

endmodule

// File: doc/core_share_arb.md
# core_share_arb

Time-shares one instance of the 14-input / 8-output combinational logic core among NREQ requesters. Round-robin arbitration picks one requester per transaction. The block registers the winner's input vector onto the core and waits a fixed number of settle cycles. It then captures the core output and returns it to the winner over a valid/ready response channel. It sits between the requester fabric and the core netlist, and is the only driver of the core inputs.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- IN_W, 14, core input width
- OUT_W, 8, core output width
- SETTLE, 2, cycles the core input is held before its output is captured (≥1)
- CNT_W, 16, width of each per-requester grant counter

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_data  in  NREQ*IN_W  per-requester input vector; slice i is bits [i*IN_W +: IN_W]
- req_ready  out  NREQ  one-hot grant/accept strobe
- rsp_valid  out  NREQ  one-hot response valid, addressed to the granted requester
- rsp_data  out  OUT_W  captured core output, shared by all requesters
- rsp_ready  in  NREQ  per-requester response ready
- core_in  out  IN_W  registered drive to the core inputs
- core_out  in  OUT_W  core outputs
- busy  out  1  high whenever the FSM is not in IDLE
- stats_clr  in  1  synchronous clear of all grant counters
- grant_cnt  out  NREQ*CNT_W  per-requester grant counters

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - The round-robin search starts at last_grant+1 and wraps modulo NREQ.
  - The first requester with req_valid set is the winner g.
  - req_ready[g] is asserted combinationally in this state only.
  - With no valid requester, req_ready is 0 and the FSM stays in IDLE.
- Handshake (IDLE and req_valid[g], which implies req_ready[g]):
  - core_in <= req_data slice g.
  - last_grant <= g.
  - settle_cnt <= SETTLE-1.
  - Next state is SETTLE.
- SETTLE:
  - While settle_cnt ≠ 0, settle_cnt decrements each cycle.
  - When settle_cnt = 0: rsp_data <= core_out, rsp_valid <= one-hot(g), next state is RESP.
- RESP:
  - rsp_valid[g] and rsp_data are held stable until rsp_ready[g] is seen.
  - On that handshake, rsp_valid clears and the FSM returns to IDLE.
  - rsp_ready bits other than g are ignored.
- core_in holds its last value between transactions.
- Requesters must hold req_valid and req_data stable until accepted. Deasserting req_valid before acceptance simply removes the requester from arbitration.
- Reset values:
  - FSM in IDLE.
  - core_in = 0, rsp_data = 0, rsp_valid = 0, req_ready = 0 while in reset, busy = 0.
  - last_grant = NREQ-1, so requester 0 has first priority after reset.
  - settle_cnt = 0, all grant_cnt = 0.
- Reset asserted mid-transaction: all state returns to the reset values immediately (asynchronously). The in-flight transaction is discarded and no response is issued for it.

## Timing
- Request handshake in cycle T → core_in shows the new vector in cycle T+1.
- rsp_valid[g] is asserted from cycle T+SETTLE+1. With SETTLE=2 that is T+3.
- Response handshake in cycle R → busy is low and req_ready may assert in cycle R+1.
- Minimum period is SETTLE+2 cycles per transaction (4 with defaults).
- Simultaneous requests: exactly one grant per IDLE cycle. Under continuous full load, NREQ requesters are served in strict rotation, so no requester waits more than NREQ-1 transactions.
- A request arriving while busy is not accepted and waits for IDLE.

## Configuration
- CORE_ARB_STATS_EN defined:
  - grant_cnt[i] increments on each request handshake of requester i.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - stats_clr zeroes all counters on the next edge.
  - If stats_clr coincides with a handshake, clear wins and the counter becomes 0.
- CORE_ARB_STATS_EN undefined:
  - No counter flops are built.
  - grant_cnt is tied to 0 and stats_clr is ignored.
  - The port list is unchanged.

## Test plan
- Reset release; at cycle 0 only req_valid[2] is set with data 14'h1A5, SETTLE=2, and core modelled as the reference netlist → req_ready=4'b0100 in cycle 0; core_in=14'h1A5 in cycle 1; rsp_valid=4'b0100 in cycle 3 with rsp_data equal to the model output.
- All four req_valid held high for 8 transactions with rsp_ready=4'hF → grant order 0,1,2,3,0,1,2,3; one grant every 4 cycles; busy low exactly one cycle between transactions.
- rsp_ready[g] held low for 5 cycles after rsp_valid while other requesters are valid → rsp_valid and rsp_data stay stable, no req_ready asserts, and other rsp_ready bits have no effect.
- rst_n pulsed low during SETTLE → outputs immediately return to reset values; no rsp_valid for that transaction; the next grant goes to requester 0.
- With CORE_ARB_STATS_EN, CNT_W=2, and requester 1 granted 5 times → grant_cnt[1] reads 3. stats_clr coincident with the 6th grant → 0. Without the macro, grant_cnt stays 0.
